morse_pattern_reg: RTL and testbench



---
 rtl/morse_pattern_reg.sv | 88 ++++++++
 tb/tb_morse_pattern_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/morse_pattern_reg.sv
// Morse letter pattern register: loads a symbol pattern with a length and
// emits one dot/dash per accepted shift, flagging clamped loads and idle shifts.
module morse_pattern_reg #(
    parameter int unsigned MAX_LEN   = 4,
    parameter int unsigned LEN_W     = 3,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [LEN_W-1:0]   len_d,
    input  logic [MAX_LEN-1:0] pat_d,
    input  logic               shift,
    output logic [LEN_W-1:0]   len_q,
    output logic [LEN_W-1:0]   remaining,
    output logic               empty,
    output logic               sym_out,
    output logic               sym_valid,
    output logic               last,
    output logic               err
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   rem_r;

    logic               over_len;
    logic [LEN_W-1:0]   load_len;
    logic               head_sym;
    logic [MAX_LEN-1:0] pat_next;

    // Clamp the requested length and pick the symbol at the emitting end.
    always_comb begin
        over_len = 1'b0;
        load_len = len_d;
        head_sym = 1'b0;
        pat_next = pat_r;
        if (len_d > MAX_LEN_L) begin
            over_len = 1'b1;
            load_len = MAX_LEN_L;
        end
        if (MSB_FIRST != 0) begin
            head_sym = pat_r[MAX_LEN-1];
            pat_next = pat_r << 1;
        end else begin
            head_sym = pat_r[0];
            pat_next = pat_r >> 1;
        end
    end

    // Load has priority over shift; pulses clear every cycle unless re-armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r     <= '0;
            rem_r     <= '0;
            len_q     <= '0;
            sym_out   <= 1'b0;
            sym_valid <= 1'b0;
            last      <= 1'b0;
            err       <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            last      <= 1'b0;
            err       <= 1'b0;
            if (ld) begin
                pat_r <= pat_d;
                len_q <= load_len;
                rem_r <= load_len;
                err   <= over_len;
            end else if (shift) begin
                if (rem_r != '0) begin
                    sym_out   <= head_sym;
                    pat_r     <= pat_next;
                    rem_r     <= rem_r - LEN_W'(1);
                    sym_valid <= 1'b1;
                    last      <= (rem_r == LEN_W'(1));
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign remaining = rem_r;
    assign empty     = (rem_r == '0);

endmodule

// File: tb/tb_morse_pattern_reg.sv
// Bench for morse_pattern_reg: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a queue-of-symbols model.
module tb_morse_pattern_reg;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = 3;

    logic               clk = 1'b0;
    logic               reset, ld, shift;
    logic [LEN_W-1:0]   len_d;
    logic [MAX_LEN-1:0] pat_d;

    logic [LEN_W-1:0] len_q0, rem0, len_q1, rem1;
    logic             empty0, sym0, valid0, last0, err0;
    logic             empty1, sym1, valid1, last1, err1;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    // Model: per instance, the symbols still to come in emission order.
    bit q0[$];
    bit q1[$];
    int exp_len;
    bit exp_sym[2];
    bit exp_valid[2];
    bit exp_last[2];
    bit exp_err;

    always #5 clk = ~clk;

    morse_pattern_reg #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .MSB_FIRST(0)) dut0 (
        .clk(clk), .reset(reset), .ld(ld), .len_d(len_d), .pat_d(pat_d), .shift(shift),
        .len_q(len_q0), .remaining(rem0), .empty(empty0), .sym_out(sym0),
        .sym_valid(valid0), .last(last0), .err(err0)
    );

    morse_pattern_reg #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .MSB_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .ld(ld), .len_d(len_d), .pat_d(pat_d), .shift(shift),
        .len_q(len_q1), .remaining(rem1), .empty(empty1), .sym_out(sym1),
        .sym_valid(valid1), .last(last1), .err(err1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input bit r, input bit l, input int len,
                              input logic [MAX_LEN-1:0] p, input bit s);
        int n;
        exp_valid = '{0, 0};
        exp_last  = '{0, 0};
        exp_err   = 0;
        if (r) begin
            q0.delete(); q1.delete();
            exp_len = 0;
            exp_sym = '{0, 0};
        end else if (l) begin
            n = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
            exp_err = (len > int'(MAX_LEN));
            exp_len = n;
            q0.delete(); q1.delete();
            for (int i = 0; i < n; i++) begin
                q0.push_back(p[i]);
                q1.push_back(p[int'(MAX_LEN) - 1 - i]);
            end
        end else if (s) begin
            if (q0.size() == 0) begin
                exp_err = 1;
            end else begin
                exp_sym[0]   = q0.pop_front();
                exp_sym[1]   = q1.pop_front();
                exp_valid    = '{1, 1};
                exp_last[0]  = (q0.size() == 0);
                exp_last[1]  = (q1.size() == 0);
            end
        end
    endtask

    task automatic step(input bit r, input bit l, input int len,
                        input logic [MAX_LEN-1:0] p, input bit s);
        reset = r; ld = l; len_d = LEN_W'(len); pat_d = p; shift = s;
        @(posedge clk);
        model_edge(r, l, len, p, s);
        #1;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run) begin
            chk("len_q0", int'(len_q0), exp_len);
            chk("remaining0", int'(rem0), q0.size());
            chk("empty0", int'(empty0), int'(q0.size() == 0));
            chk("sym_out0", int'(sym0), int'(exp_sym[0]));
            chk("sym_valid0", int'(valid0), int'(exp_valid[0]));
            chk("last0", int'(last0), int'(exp_last[0]));
            chk("err0", int'(err0), int'(exp_err));
            chk("len_q1", int'(len_q1), exp_len);
            chk("remaining1", int'(rem1), q1.size());
            chk("empty1", int'(empty1), int'(q1.size() == 0));
            chk("sym_out1", int'(sym1), int'(exp_sym[1]));
            chk("sym_valid1", int'(valid1), int'(exp_valid[1]));
            chk("last1", int'(last1), int'(exp_last[1]));
            chk("err1", int'(err1), int'(exp_err));
        end
    end

    initial begin
        reset = 1'b1; ld = 1'b0; shift = 1'b0; len_d = '0; pat_d = '0;
        step(1, 1, 3, 4'b1111, 1);
        run = 1'b1;
        chk("rst_rem", int'(rem0), 0);
        chk("rst_empty", int'(empty0), 1);
        chk("rst_len", int'(len_q1), 0);

        // LSB-first 0110 length 3 -> 0,1,1
        step(0, 1, 3, 4'b0110, 0);
        chk("ld3_rem", int'(rem0), 3);
        step(0, 0, 0, 4'b0000, 1);
        chk("s1_sym", int'(sym0), 0); chk("s1_valid", int'(valid0), 1); chk("s1_rem", int'(rem0), 2);
        step(0, 0, 0, 4'b0000, 1);
        chk("s2_sym", int'(sym0), 1); chk("s2_rem", int'(rem0), 1); chk("s2_last", int'(last0), 0);
        step(0, 0, 0, 4'b0000, 1);
        chk("s3_sym", int'(sym0), 1); chk("s3_last", int'(last0), 1); chk("s3_empty", int'(empty0), 1);
        step(0, 0, 0, 4'b0000, 0);
        chk("hold_sym", int'(sym0), 1); chk("pulse_end", int'(valid0), 0);

        // MSB-first 1000 length 4 -> 1,0,0,0
        step(0, 1, 4, 4'b1000, 0);
        step(0, 0, 0, 4'b0000, 1);
        chk("m1_sym", int'(sym1), 1);
        step(0, 0, 0, 4'b0000, 1);
        chk("m2_sym", int'(sym1), 0);
        step(0, 0, 0, 4'b0000, 1);
        step(0, 0, 0, 4'b0000, 1);
        chk("m4_sym", int'(sym1), 0); chk("m4_last", int'(last1), 1);

        // Shift while empty, then clamped load, then ld+shift collision
        step(0, 0, 0, 4'b0000, 1);
        chk("empty_err", int'(err0), 1); chk("empty_valid", int'(valid0), 0); chk("empty_rem", int'(rem0), 0);
        step(0, 1, 7, 4'b1010, 0);
        chk("clamp_len", int'(len_q0), 4); chk("clamp_rem", int'(rem0), 4); chk("clamp_err", int'(err0), 1);
        step(0, 0, 0, 4'b0000, 0);
        chk("clamp_err_pulse", int'(err0), 0);
        step(0, 1, 2, 4'b0011, 1);
        chk("ldsh_err", int'(err0), 0); chk("ldsh_rem", int'(rem0), 2); chk("ldsh_valid", int'(valid0), 0);

        // Reset mid-letter discards it
        step(0, 1, 3, 4'b0111, 0);
        step(0, 0, 0, 4'b0000, 1);
        step(1, 0, 0, 4'b0000, 1);
        chk("mrst_sym", int'(sym0), 0); chk("mrst_empty", int'(empty0), 1); chk("mrst_len", int'(len_q0), 0);
        step(0, 0, 0, 4'b0000, 1);
        chk("mrst_novalid", int'(valid0), 0);

        // Reload mid-letter aborts it
        step(0, 1, 4, 4'b1011, 0);
        step(0, 0, 0, 4'b0000, 1);
        step(0, 1, 2, 4'b0110, 0);
        chk("reload_rem", int'(rem0), 2);
        step(0, 0, 0, 4'b0000, 1);
        chk("reload_sym", int'(sym0), 0);

        // Length zero load
        step(0, 1, 0, 4'b1111, 0);
        chk("len0_empty", int'(empty0), 1);
        step(0, 0, 0, 4'b0000, 1);
        chk("len0_err", int'(err0), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
